// File: rtl/load_store_sequencer_pkg.sv
// Shared definitions for the load/store control sequencer.
//   state_t        : sequencer state encoding (4 bits, IDLE = 0)
//   DEF_OP_*       : default opcode values for LD, LDI and ST
//   is_mem_state() : true for the states that wait on a memory handshake
package seq_defs;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    F_MAR  = 4'd1,
    F_RD   = 4'd2,
    F_IR   = 4'd3,
    DECODE = 4'd4,
    L_MAR  = 4'd5,
    L_RD   = 4'd6,
    L_WB   = 4'd7,
    I_WB   = 4'd8,
    S_MAR  = 4'd9,
    S_MDR  = 4'd10,
    S_WR   = 4'd11,
    DONE   = 4'd12
  } state_t;

  localparam logic [4:0] DEF_OP_LD  = 5'd0;
  localparam logic [4:0] DEF_OP_LDI = 5'd1;
  localparam logic [4:0] DEF_OP_ST  = 5'd2;

  function automatic logic is_mem_state(input state_t s);
    return (s == F_RD) || (s == L_RD) || (s == S_WR);
  endfunction

endpackage

// File: rtl/load_store_sequencer_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes.
//   clock   : system clock
//   clear   : synchronous active-high reset, zeroes the count
//   load    : restart the count at zero (held while outside a memory state)
//   enable  : count one more wait cycle
//   timeout : count has reached TIMEOUT-1, the last cycle of the budget
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (clear || load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/load_store_sequencer.sv
// Control sequencer for instruction fetch and LD / LDI / ST execution.
// Emits datapath strobes only; the IR opcode field is read back from the
// datapath.
//   clock, clear        : clock and synchronous active-high reset
//   start, run          : single-instruction kick / free-run mode
//   opcode              : IR opcode field, valid from DECODE onward
//   mem_ready           : memory finished the current access this cycle
//   pco .. rout         : datapath strobes
//   mdr_bus_sel         : 1 = MDR loads from bus, 0 = from memory
//   mem_read, mem_write : memory commands
//   busy, done          : not idle / one-cycle retire pulse
//   illegal, bus_err    : sticky unknown-opcode / memory-timeout flags
//   instr_count         : retired instruction count (wraps)
module load_store_sequencer
  import seq_defs::*;
#(
  parameter int                  OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(DEF_OP_LD),
  parameter logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(DEF_OP_LDI),
  parameter logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(DEF_OP_ST),
  parameter int                  TIMEOUT  = 16,
  parameter int                  CNT_W    = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pco,
  output logic                mari,
  output logic                mdri,
  output logic                mdro,
  output logic                iri,
  output logic                pc_inc,
  output logic                csigno,
  output logic                gra,
  output logic                rin,
  output logic                rout,
  output logic                mdr_bus_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    instr_count
);

  state_t state, next_state;
  logic   set_illegal, set_bus_err;
  logic   tmr_load, tmr_en, tmr_timeout;

  // Every memory state is entered from a non-memory state, so holding the
  // timer at zero outside them gives each access a fresh budget.
  assign tmr_load = !is_mem_state(state);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .clear   (clear),
    .load    (tmr_load),
    .enable  (tmr_en),
    .timeout (tmr_timeout)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        illegal <= 1'b0;
        bus_err <= 1'b0;
      end
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
      if (state == DONE) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state  = state;
    pco         = 1'b0;
    mari        = 1'b0;
    mdri        = 1'b0;
    mdro        = 1'b0;
    iri         = 1'b0;
    pc_inc      = 1'b0;
    csigno      = 1'b0;
    gra         = 1'b0;
    rin         = 1'b0;
    rout        = 1'b0;
    mdr_bus_sel = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    done        = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    tmr_en      = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE:   if (start || run) next_state = F_MAR;
      F_MAR: begin
        pco = 1'b1; mari = 1'b1; next_state = F_RD;
      end
      F_RD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          mdri = 1'b1; next_state = F_IR;
        end else if (tmr_timeout) begin
          set_bus_err = 1'b1; next_state = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      F_IR: begin
        mdro = 1'b1; iri = 1'b1; pc_inc = 1'b1; next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LD:   next_state = L_MAR;
          OP_LDI:  next_state = I_WB;
          OP_ST:   next_state = S_MAR;
          default: begin
            set_illegal = 1'b1; next_state = IDLE;
          end
        endcase
      end
      L_MAR: begin
        csigno = 1'b1; mari = 1'b1; next_state = L_RD;
      end
      L_RD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          mdri = 1'b1; next_state = L_WB;
        end else if (tmr_timeout) begin
          set_bus_err = 1'b1; next_state = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      L_WB: begin
        mdro = 1'b1; gra = 1'b1; rin = 1'b1; next_state = DONE;
      end
      I_WB: begin
        csigno = 1'b1; gra = 1'b1; rin = 1'b1; next_state = DONE;
      end
      S_MAR: begin
        csigno = 1'b1; mari = 1'b1; next_state = S_MDR;
      end
      S_MDR: begin
        gra = 1'b1; rout = 1'b1; mdri = 1'b1; mdr_bus_sel = 1'b1;
        next_state = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          next_state = DONE;
        end else if (tmr_timeout) begin
          set_bus_err = 1'b1; next_state = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        next_state = run ? F_MAR : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
